// File: rtl/ram_bist_pkg.sv
// Shared definitions for the March C- RAM self-test controller: state encoding,
// element indices, access phase and per-element direction/background tables.
package ram_bist_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_M0,
    S_M1,
    S_M2,
    S_M3,
    S_M4,
    S_M5,
    S_CHK,
    S_END
  } state_t;

  localparam logic [2:0] ELEM_M0 = 3'd0;
  localparam logic [2:0] ELEM_M1 = 3'd1;
  localparam logic [2:0] ELEM_M2 = 3'd2;
  localparam logic [2:0] ELEM_M3 = 3'd3;
  localparam logic [2:0] ELEM_M4 = 3'd4;
  localparam logic [2:0] ELEM_M5 = 3'd5;

  localparam logic PH_RD = 1'b0;
  localparam logic PH_WR = 1'b1;

  // Bit i describes element i; a background bit is replicated across the word.
  localparam logic [7:0] ELEM_DOWN = 8'b0001_1000;  // M3, M4 descend
  localparam logic [7:0] ELEM_EXP  = 8'b0001_0100;  // read O in M2, M4
  localparam logic [7:0] ELEM_WRB  = 8'b0000_1010;  // write O in M1, M3

  function automatic logic [2:0] state_elem(state_t s);
    case (s)
      S_M1:    return ELEM_M1;
      S_M2:    return ELEM_M2;
      S_M3:    return ELEM_M3;
      S_M4:    return ELEM_M4;
      S_M5:    return ELEM_M5;
      default: return ELEM_M0;
    endcase
  endfunction

  function automatic state_t next_elem_state(state_t s);
    case (s)
      S_M0:    return S_M1;
      S_M1:    return S_M2;
      S_M2:    return S_M3;
      S_M3:    return S_M4;
      S_M4:    return S_M5;
      S_M5:    return S_CHK;
      default: return S_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/bist_addr_gen.sv
// Up/down march address counter with load-to-start (0 or DEP-1) and an
// end-of-element flag that depends on the current direction.
module bist_addr_gen #(
  parameter int DEP   = 64,
  parameter int ADD_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic             load_down,
  input  logic             down,
  output logic [ADD_W-1:0] addr,
  output logic             last
);

  localparam logic [ADD_W-1:0] TOP = ADD_W'(DEP - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
    end else if (load) begin
      addr <= load_down ? TOP : '0;
    end else if (en) begin
      addr <= down ? (addr - 1'b1) : (addr + 1'b1);
    end
  end

  assign last = down ? (addr == '0) : (addr == TOP);

endmodule

// File: rtl/ram_bist.sv
// March C- BIST controller for a single-port registered-read RAM; reports
// pass/fail and the first failing address, element and read data.
module ram_bist
  import ram_bist_pkg::*;
#(
  parameter int DEP   = 64,
  parameter int WID   = 16,
  parameter int ADD_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ADD_W-1:0] fail_addr,
  output logic [2:0]       fail_elem,
  output logic [WID-1:0]   fail_data,
  output logic             ram_wr,
  output logic [ADD_W-1:0] ram_addr,
  output logic [WID-1:0]   ram_din,
  input  logic [WID-1:0]   ram_dout
);

  state_t           state_q, state_d, nxt;
  logic             ph_q, ph_d;
  logic [2:0]       elem, cmp_elem;
  logic             ag_en, ag_load, ag_load_down, ag_last;
  logic [ADD_W-1:0] ag_addr, cmp_addr;
  logic             wr_req, din_bit, cmp_en, exp_bit, step, mismatch;
  logic             vld_p1;
  logic [ADD_W-1:0] addr_p1;

  assign elem = state_elem(state_q);

  bist_addr_gen #(
    .DEP   (DEP),
    .ADD_W (ADD_W)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .en        (ag_en),
    .load      (ag_load),
    .load_down (ag_load_down),
    .down      (ELEM_DOWN[elem]),
    .addr      (ag_addr),
    .last      (ag_last)
  );

  always_comb begin
    state_d      = state_q;
    ph_d         = ph_q;
    nxt          = state_q;
    ag_en        = 1'b0;
    ag_load      = 1'b0;
    ag_load_down = 1'b0;
    wr_req       = 1'b0;
    din_bit      = 1'b0;
    cmp_en       = 1'b0;
    exp_bit      = 1'b0;
    cmp_elem     = elem;
    cmp_addr     = ag_addr;
    step         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_M0;
          ag_load = 1'b1;
          ph_d    = PH_RD;
        end
      end
      S_M0: begin
        wr_req = 1'b1;
        step   = 1'b1;
      end
      S_M1, S_M2, S_M3, S_M4: begin
        if (ph_q == PH_RD) begin
          ph_d = PH_WR;
        end else begin
          wr_req  = 1'b1;
          din_bit = ELEM_WRB[elem];
          cmp_en  = 1'b1;
          exp_bit = ELEM_EXP[elem];
          step    = 1'b1;
          ph_d    = PH_RD;
        end
      end
      // M5 reads every cycle; the compare trails the read by one cycle.
      S_M5: begin
        step     = 1'b1;
        cmp_en   = vld_p1;
        cmp_addr = addr_p1;
      end
      S_CHK: begin
        cmp_en   = vld_p1;
        cmp_addr = addr_p1;
        cmp_elem = ELEM_M5;
        state_d  = S_END;
      end
      S_END: begin
        state_d = S_IDLE;
        ag_load = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (step) begin
      nxt = next_elem_state(state_q);
      if (ag_last) begin
        state_d      = nxt;
        ag_load      = 1'b1;
        ag_load_down = ELEM_DOWN[state_elem(nxt)];
      end else begin
        ag_en = 1'b1;
      end
    end

    // A mismatch suppresses the write scheduled for this same cycle.
    mismatch = cmp_en && (ram_dout != {WID{exp_bit}});
    if (mismatch) begin
      state_d      = S_END;
      wr_req       = 1'b0;
      ag_en        = 1'b0;
      ag_load      = 1'b1;
      ag_load_down = 1'b0;
      ph_d         = PH_RD;
    end
  end

  assign busy     = (state_q != S_IDLE) && (state_q != S_END);
  assign done     = (state_q == S_END);
  assign ram_wr   = wr_req;
  assign ram_addr = ag_addr;
  assign ram_din  = wr_req ? {WID{din_bit}} : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ph_q      <= PH_RD;
      vld_p1    <= 1'b0;
      pass      <= 1'b0;
      fail_addr <= '0;
      fail_elem <= '0;
      fail_data <= '0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      vld_p1  <= (state_q == S_M5) && !mismatch;
      if (state_q == S_IDLE && start) begin
        pass      <= 1'b0;
        fail_addr <= '0;
        fail_elem <= '0;
        fail_data <= '0;
      end else if (mismatch) begin
        fail_addr <= cmp_addr;
        fail_elem <= cmp_elem;
        fail_data <= ram_dout;
      end else if (state_q == S_CHK) begin
        pass <= 1'b1;
      end
    end
  end

  // p1: address of the read issued in the previous cycle
  always_ff @(posedge clk) begin
    addr_p1 <= ag_addr;
  end

endmodule

// File: tb/tb_ram_bist.sv
// Bench for ram_bist: behavioural registered-read RAM with selectable faults,
// a table of full-run vectors and hand-written multi-cycle sequences.
module tb_ram_bist;

  localparam int DEP   = 64;
  localparam int WID   = 16;
  localparam int ADD_W = 6;
  localparam int MAXC  = 3000;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             busy, done, pass;
  logic [ADD_W-1:0] fail_addr;
  logic [2:0]       fail_elem;
  logic [WID-1:0]   fail_data;
  logic             ram_wr;
  logic [ADD_W-1:0] ram_addr;
  logic [WID-1:0]   ram_din;
  logic [WID-1:0]   ram_dout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_bist #(.DEP(DEP), .WID(WID), .ADD_W(ADD_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_addr (fail_addr),
    .fail_elem (fail_elem),
    .fail_data (fail_data),
    .ram_wr    (ram_wr),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout)
  );

  // RAM model: 0 = good, 1 = data_out[3] stuck high on reads of addr 10,
  // 2 = address 63 aliases onto address 0.
  int               fault_mode = 0;
  logic [WID-1:0]   mem [DEP];
  logic [ADD_W-1:0] eff_addr;
  logic [WID-1:0]   rd_val;
  logic             ram_rstn;

  assign ram_rstn = !rst;

  always_comb begin
    eff_addr = ram_addr;
    if (fault_mode == 2 && ram_addr == 6'd63) eff_addr = 6'd0;
    rd_val = mem[eff_addr];
    if (fault_mode == 1 && ram_addr == 6'd10) rd_val[3] = 1'b1;
  end

  always @(posedge clk) begin
    if (!ram_rstn) ram_dout <= '0;
    else if (ram_wr) mem[eff_addr] <= ram_din;
    else ram_dout <= rd_val;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  logic [ADD_W-1:0] addr_log [MAXC];
  logic             wr_log   [MAXC];
  logic             first_wr, first_pass;
  logic [ADD_W-1:0] first_addr, first_fa;

  // Pulse start, then count busy cycles until done; returns at the END cycle.
  task automatic run(input int repulse_at, output int ncyc, output bit got_done);
    ncyc = 0;
    got_done = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    first_wr   = ram_wr;
    first_addr = ram_addr;
    first_pass = pass;
    first_fa   = fail_addr;
    for (int c = 0; c < MAXC; c++) begin
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (busy) begin
        addr_log[ncyc] = ram_addr;
        wr_log[ncyc]   = ram_wr;
        ncyc++;
      end
      start = (c == repulse_at);
      @(negedge clk);
    end
    start = 1'b0;
    if (!got_done) begin
      checks++;
      errors++;
      $display("FAIL run_timeout actual=no_done required=done_within_%0d", MAXC);
    end
  endtask

  typedef struct {
    int              fault;
    int              ncyc;
    logic            pass;
    logic [ADD_W-1:0] fa;
    logic [2:0]      fe;
    logic [WID-1:0]  fd;
    logic [WID-1:0]  mem10;
  } vec_t;

  vec_t vecs [3];

  initial begin
    int  n;
    bit  gd;
    int  wcnt;
    int  bad;

    for (int i = 0; i < DEP; i++) mem[i] = '0;

    vecs[0] = '{fault: 0, ncyc: 641, pass: 1'b1, fa: 6'd0,  fe: 3'd0, fd: 16'h0000, mem10: 16'h0000};
    vecs[1] = '{fault: 1, ncyc: 86,  pass: 1'b0, fa: 6'd10, fe: 3'd1, fd: 16'h0008, mem10: 16'h0000};
    vecs[2] = '{fault: 2, ncyc: 192, pass: 1'b0, fa: 6'd63, fe: 3'd1, fd: 16'hFFFF, mem10: 16'hFFFF};

    repeat (3) @(negedge clk);
    chk("reset_outputs", {busy, done, pass, fail_addr, fail_elem, fail_data, ram_wr, ram_addr, ram_din},
        '0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_port", {ram_wr, ram_addr, ram_din}, '0);

    for (int i = 0; i < 3; i++) begin
      fault_mode = vecs[i].fault;
      run(-1, n, gd);
      chk("first_m0_write", {first_wr, first_addr}, {1'b1, 6'd0});
      chk("start_clears", {first_pass, first_fa}, '0);
      chk("busy_cycles", n, vecs[i].ncyc);
      chk("done_busy_low", {done, busy}, {1'b1, 1'b0});
      chk("pass", pass, vecs[i].pass);
      chk("fail_addr", fail_addr, vecs[i].fa);
      chk("fail_elem", fail_elem, vecs[i].fe);
      chk("fail_data", fail_data, vecs[i].fd);
      chk("mem10_after", mem[10], vecs[i].mem10);
      @(negedge clk);
      chk("done_one_cycle", {done, busy, pass, fail_addr}, {1'b0, 1'b0, vecs[i].pass, vecs[i].fa});
    end

    // Fault-free run with a start re-pulse while busy, then start during END.
    fault_mode = 0;
    run(50, n, gd);
    chk("repulse_len", n, 641);
    chk("repulse_pass", pass, 1'b1);
    chk("m2_tail", {addr_log[316], addr_log[317], addr_log[318], addr_log[319]},
        {6'd62, 6'd62, 6'd63, 6'd63});
    chk("m3_head", {addr_log[320], addr_log[321], addr_log[322], addr_log[323]},
        {6'd63, 6'd63, 6'd62, 6'd62});
    bad = 0;
    for (int k = 0; k < 128; k++)
      if (addr_log[320 + k] != 6'(63 - k / 2)) bad++;
    chk("m3_sequence_errs", bad, 0);
    chk("m4_start", addr_log[448], 6'd63);
    wcnt = 0;
    for (int k = 0; k < 641; k++) if (wr_log[k]) wcnt++;
    chk("write_cycles", wcnt, 320);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_in_end_ignored", {busy, done}, 2'b00);
    @(negedge clk);
    chk("still_idle", busy, 1'b0);

    // Reset in the middle of a test, then a clean rerun.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (299) @(negedge clk);
    chk("midtest_busy", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_abort_outputs", {busy, done, pass, fail_addr, fail_elem, fail_data, ram_wr, ram_addr, ram_din},
        '0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_stays_idle", {busy, ram_wr}, 2'b00);
    run(-1, n, gd);
    chk("after_rst_len", n, 641);
    chk("after_rst_pass", pass, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_bist.md
# ram_bist

March-style built-in self-test controller that drives the team's single-port RAM (`ram`, DEP×WID, registered read). It acts as the RAM's access initiator: it issues the write and read commands, compares the read data, and reports pass/fail plus the first failing location. It sits between the RAM and system test control, muxed onto the RAM port while `busy`.

## Interface
Parameters:
- `DEP`, 64, RAM depth in words
- `WID`, 16, RAM data width
- `ADD_W`, 6, address width; must satisfy DEP = 2**ADD_W

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle request; accepted only in IDLE
- `busy`  out  1  test in progress
- `done`  out  1  one-cycle pulse at test end (pass or fail)
- `pass`  out  1  result of the last completed test; held until the next accepted `start`
- `fail_addr`  out  ADD_W  address of the first mismatch
- `fail_elem`  out  3  march element (0–5) of the first mismatch
- `fail_data`  out  WID  read data that mismatched
- `ram_wr`  out  1  to RAM `wr`: 1 = write, 0 = read
- `ram_addr`  out  ADD_W  to RAM `addr`
- `ram_din`  out  WID  to RAM `data_in`
- `ram_dout`  in  WID  from RAM `data_out`; valid the cycle after a read is issued

## Operation
- The test runs March C- with backgrounds Z = {WID{1'b0}} and O = {WID{1'b1}}:
  - M0 ↑ w Z
  - M1 ↑ (r Z, w O)
  - M2 ↑ (r O, w Z)
  - M3 ↓ (r Z, w O)
  - M4 ↓ (r O, w Z)
  - M5 ↑ r Z
- States: IDLE, M0–M5, CHK (final compare), END.
- Each M1–M4 element uses two cycles per address:
  - RD: `ram_wr`=0 at `ram_addr`=a.
  - WR: `ram_wr`=1 at the same a, with `ram_din` set to the new background. In this same cycle `ram_dout` is compared against the expected background.
- M5 is pipelined: a read is issued every cycle, and each cycle compares the previous cycle's read. CHK compares the last read (addr 0 is not re-read; `ram_wr`=0 in CHK).
- ↑ runs 0→DEP-1. ↓ runs DEP-1→0. The address counter wraps to the next element's start address with no idle cycle between elements.
- On the first mismatch:
  - Capture `fail_addr`, `fail_elem` and `fail_data`.
  - Abort the rest of the test and go to END. No further writes are issued.
- END lasts one cycle: `done`=1, `busy`=0, `pass` = (no mismatch). Then return to IDLE.
- `start` while busy or in END is ignored.
- In IDLE, `ram_wr`=0, `ram_addr`=0 and `ram_din`=0, so the RAM is never written outside a test.

## Timing
- Reset values: `busy`=0, `done`=0, `pass`=0, `fail_addr`=0, `fail_elem`=0, `fail_data`=0, `ram_wr`=0, `ram_addr`=0, `ram_din`=0. State = IDLE.
- `rst` mid-test aborts on the next edge to the reset values. No partial write is issued after that edge.
- `start` sampled high at edge t:
  - `busy`=1 from t.
  - The first M0 write drives the RAM port in cycle t..t+1.
- Fault-free run: `busy` is high for exactly 10·DEP+1 cycles (641 for DEP=64). M0 = DEP, M1–M4 = 2·DEP each, M5 = DEP, CHK = 1.
- `done` pulses in the cycle after `busy` falls.
- Fail path: END follows the mismatch cycle by exactly one edge.
- `fail_*` outputs are cleared on `start` acceptance and hold after `done`.

## Structure
- Package `ram_bist_pkg` holds:
  - state encoding
  - element indices M0–M5
  - the RD/WR phase bit
  - per-element direction and expected/write background constants
- Sub-module `bist_addr_gen`: an ADD_W-bit up/down counter with load-to-start (0 or DEP-1), `last` flag and enable. The FSM and comparator live in `ram_bist`.

## Test plan
Bench: `ram_bist` connected to `ram` (DEP=64, WID=16), RAM `rstn` tied to `!rst`.
- Fault-free RAM, one `start` pulse → `busy` high for 641 cycles, `done` pulse, `pass`=1, `fail_*`=0.
- Force RAM `data_out[3]`=1 on reads of addr 10 → abort in M1: `fail_addr`=10, `fail_elem`=1, `fail_data`=16'h0008, `pass`=0.
- Address-alias wrapper (addr 63 maps to 0) → `fail_addr`=63, `fail_elem`=1, `fail_data`=16'hFFFF.
- Monitor `ram_addr` across M2→M3 → sequence …62,62,63,63 then 63,63,62,62… down to 0,0, then 63 for M4. No gap cycles.
- `start` re-pulsed at cycle 50 → ignored, total length still 641. `rst` asserted at cycle 300 → next cycle all outputs at reset values and `ram_wr`=0; a following `start` completes with `pass`=1.
